// File: rtl/vec_wb_pkg.sv
// vec_wb_pkg: shared types and helpers for the vector writeback controller.
// States, SEW/LMUL encodings and the element-capacity function.
package vec_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    WRITE,
    WAIT_ACK
  } wb_state_e;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_RSV = 2'b11
  } sew_e;

  localparam logic [3:0] LMUL1 = 4'b0001;
  localparam logic [3:0] LMUL2 = 4'b0010;
  localparam logic [3:0] LMUL4 = 4'b0100;
  localparam logic [3:0] LMUL8 = 4'b1000;

  // Number of registers in the group; 0 flags a non-one-hot LMUL.
  function automatic int lmul_regs(input logic [3:0] lmul);
    int regs;
    regs = 0;
    unique case (lmul)
      LMUL1:   regs = 1;
      LMUL2:   regs = 2;
      LMUL4:   regs = 4;
      LMUL8:   regs = 8;
      default: regs = 0;
    endcase
    return regs;
  endfunction

  function automatic logic lmul_ok(input logic [3:0] lmul);
    return lmul_regs(lmul) != 0;
  endfunction

  // Elements of width SEW that fit in the register group.
  function automatic int elem_cap(
    input logic [3:0] lmul,
    input logic [1:0] sew,
    input int         vlen
  );
    return (lmul_regs(lmul) * vlen / 8) >> sew;
  endfunction

endpackage

// File: rtl/vec_wb_merge.sv
// vec_wb_merge: per-element merge of result, old destination and v0 mask.
// VEC_WB_TAIL_AGNOSTIC_EN selects all-ones tail instead of tail-undisturbed.
module vec_wb_merge
  import vec_wb_pkg::*;
#(
  parameter int VLEN       = 512,
  parameter int DATA_WIDTH = 8 * VLEN,
  parameter int VL_WIDTH   = 13
) (
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [DATA_WIDTH-1:0] dst_data,
  input  logic [VLEN-1:0]       v0,
  input  logic [VL_WIDTH-1:0]   vl,
  input  logic [1:0]            sew,
  input  logic [3:0]            lmul,
  input  logic                  vm,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int MW = $clog2(VLEN);

  logic [VL_WIDTH-1:0] cap;
  logic [VL_WIDTH-1:0] vl_c;
  logic [MW-1:0]       eidx;
  logic                act;

  assign cap  = VL_WIDTH'(elem_cap(lmul, sew, VLEN));
  assign vl_c = (vl > cap) ? cap : vl;

  // Work byte by byte: the owning element index is byte >> sew.
  always_comb begin
    wdata = dst_data;
    eidx  = '0;
    act   = 1'b0;
    for (int b = 0; b < NB; b++) begin
      eidx = MW'(b >> sew);
      act  = VL_WIDTH'(eidx) < vl_c;
      if (act && (vm || v0[eidx])) begin
        wdata[b*8 +: 8] = res_data[b*8 +: 8];
      end
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
      else if (!act) begin
        wdata[b*8 +: 8] = 8'hFF;
      end
`endif
    end
  end

endmodule

// File: rtl/vec_wb_ctrl.sv
// vec_wb_ctrl: vector writeback FSM, result latch and ack timeout.
// Tail policy set by VEC_WB_TAIL_AGNOSTIC_EN inside vec_wb_merge.
module vec_wb_ctrl
  import vec_wb_pkg::*;
#(
  parameter int VLEN        = 512,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8 * VLEN,
  parameter int VL_WIDTH    = 13,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [ADDR_WIDTH-1:0] res_vd,
  input  logic [3:0]            res_lmul,
  input  logic [1:0]            res_sew,
  input  logic [VL_WIDTH-1:0]   res_vl,
  input  logic                  res_vm,
  input  logic [VLEN-1:0]       v0_mask_data,
  input  logic [DATA_WIDTH-1:0] dst_data,
  input  logic                  data_written,
  input  logic                  wrong_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            lmul,
  output logic                  wb_done,
  output logic                  wb_error
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  wb_state_e             state_q;
  wb_state_e             state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] vd_q;
  logic [3:0]            lmul_q;
  sew_e                  sew_q;
  logic [VL_WIDTH-1:0]   vl_q;
  logic                  vm_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged;
  logic [CW-1:0]         cnt_q;
  logic                  accept;
  logic                  bad_cfg;

  assign accept  = (state_q == IDLE) && res_valid;
  assign bad_cfg = (sew_q == SEW_RSV) || !lmul_ok(lmul_q);

  assign waddr = vd_q;
  assign lmul  = lmul_q;
  assign wdata = wdata_q;

  vec_wb_merge #(
    .VLEN       (VLEN),
    .DATA_WIDTH (DATA_WIDTH),
    .VL_WIDTH   (VL_WIDTH)
  ) u_merge (
    .res_data (data_q),
    .dst_data (dst_data),
    .v0       (v0_mask_data),
    .vl       (vl_q),
    .sew      (sew_q),
    .lmul     (lmul_q),
    .vm       (vm_q),
    .wdata    (merged)
  );

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    res_ready = 1'b0;
    wr_en     = 1'b0;
    wb_done   = 1'b0;
    wb_error  = 1'b0;
    unique case (state_q)
      IDLE: begin
        res_ready = 1'b1;
        if (res_valid) state_d = MERGE;
      end
      MERGE: begin
        if (bad_cfg) begin
          wb_error = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = WRITE;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (data_written) begin
          wb_done = 1'b1;
          state_d = IDLE;
        end else if (wrong_addr) begin
          wb_error = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
          wb_error = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the result fields on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      vd_q   <= '0;
      lmul_q <= LMUL1;
      sew_q  <= SEW8;
      vl_q   <= '0;
      vm_q   <= 1'b0;
    end else if (accept) begin
      data_q <= res_data;
      vd_q   <= res_vd;
      lmul_q <= res_lmul;
      sew_q  <= sew_e'(res_sew);
      vl_q   <= res_vl;
      vm_q   <= res_vm;
    end
  end

  // Register merged data once; held through WRITE and WAIT_ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdata_q <= '0;
    end else if (state_q == MERGE && !bad_cfg) begin
      wdata_q <= merged;
    end
  end

  // Ack timeout: zero on first WAIT_ACK cycle, counts up while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == WRITE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_ACK) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_vec_wb_ctrl.sv
// tb_vec_wb_ctrl: vector table, random transactions and corner sequences.
// Expected write data comes from an element-level reference model.
module tb_vec_wb_ctrl;

  localparam int VLEN = 512;
  localparam int AW   = 5;
  localparam int DW   = 8 * VLEN;
  localparam int VLW  = 13;
  localparam int TO   = 15;

  logic           clk;
  logic           reset;
  logic           res_valid;
  logic           res_ready;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  res_vd;
  logic [3:0]     res_lmul;
  logic [1:0]     res_sew;
  logic [VLW-1:0] res_vl;
  logic           res_vm;
  logic [VLEN-1:0] v0_mask_data;
  logic [DW-1:0]  dst_data;
  logic           data_written;
  logic           wrong_addr;
  logic           wr_en;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [3:0]     lmul;
  logic           wb_done;
  logic           wb_error;

  vec_wb_ctrl #(
    .VLEN (VLEN), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .VL_WIDTH (VLW), .ACK_TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_data (res_data), .res_vd (res_vd),
    .res_lmul (res_lmul), .res_sew (res_sew),
    .res_vl (res_vl), .res_vm (res_vm),
    .v0_mask_data (v0_mask_data), .dst_data (dst_data),
    .data_written (data_written), .wrong_addr (wrong_addr),
    .wr_en (wr_en), .waddr (waddr), .wdata (wdata),
    .lmul (lmul), .wb_done (wb_done), .wb_error (wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  logic [DW-1:0] exp_w;
  logic [DW-1:0] last_w;

  typedef struct {
    logic [3:0]    lm;
    logic [1:0]    sw;
    int            vl;
    bit            vm;
    logic [AW-1:0] vd;
    int            kind;
    int            dly;
    int            pat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got %0h want %0h", nm, got, exp);
  endtask

  task automatic check_wide(input string nm, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
    int w;
    w = 0;
    total++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      for (w = 0; w < DW / 32; w++)
        if (got[w*32 +: 32] !== exp[w*32 +: 32]) break;
      $display("FAIL %s word %0d got %h want %h", nm, w,
               got[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  // Element-level reference: active & enabled -> result, else old
  // destination; the tail is all-ones under the agnostic build.
  function automatic logic [DW-1:0] model(
    input logic [DW-1:0] rd, input logic [DW-1:0] dd,
    input logic [VLEN-1:0] v0, input logic [3:0] lm,
    input logic [1:0] sw, input int vl, input bit vm);
    logic [DW-1:0] r;
    int ew, regs, cap, vlc, n;
    bit act, take;
    ew   = 8 << sw;
    regs = (lm == 4'd1) ? 1 : (lm == 4'd2) ? 2 : (lm == 4'd4) ? 4 : 8;
    cap  = regs * VLEN / ew;
    vlc  = (vl > cap) ? cap : vl;
    n    = DW / ew;
    r    = dd;
    for (int i = 0; i < n; i++) begin
      act  = i < vlc;
      take = act && (vm || v0[i]);
      for (int k = 0; k < ew; k++) begin
        if (take) r[i*ew + k] = rd[i*ew + k];
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
        else if (!act) r[i*ew + k] = 1'b1;
`endif
      end
    end
    return r;
  endfunction

  task automatic rand_fill(output logic [DW-1:0] x);
    for (int w = 0; w < DW / 32; w++) x[w*32 +: 32] = $urandom;
  endtask

  task automatic set_pat(input int pat);
    if (pat == 1) begin
      res_data     = {(DW/8){8'h11}};
      dst_data     = {(DW/8){8'hEE}};
      v0_mask_data = '0;
      v0_mask_data[7:0] = 8'b1010_0101;
    end else begin
      rand_fill(res_data);
      rand_fill(dst_data);
      for (int w = 0; w < VLEN / 32; w++)
        v0_mask_data[w*32 +: 32] = $urandom;
    end
  endtask

  // kind: 0 data_written, 1 wrong_addr, 2 both, 3 no ack (timeout).
  task automatic txn(input logic [3:0] lm, input logic [1:0] sw,
                     input int vl, input bit vm, input logic [AW-1:0] vd,
                     input int kind, input int dly, input string tag);
    int n;
    bit bad;
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready_in"}, res_ready, 1);
    res_valid = 1'b1;
    res_lmul  = lm;
    res_sew   = sw;
    res_vl    = VLW'(vl);
    res_vm    = vm;
    res_vd    = vd;
    bad = (sw == 2'b11) || !(lm == 4'd1 || lm == 4'd2 ||
                             lm == 4'd4 || lm == 4'd8);
    if (!bad) exp_w = model(res_data, dst_data, v0_mask_data,
                            lm, sw, vl, vm);
    @(negedge clk);
    res_valid = 1'b0;
    if (bad) begin
      check({tag, ":cfg_err"}, wb_error, 1);
      check({tag, ":cfg_wr"}, wr_en, 0);
      @(negedge clk);
      check({tag, ":cfg_wr2"}, wr_en, 0);
      check({tag, ":cfg_rdy"}, res_ready, 1);
      return;
    end
    check({tag, ":merge_err"}, wb_error, 0);
    check({tag, ":merge_addr"}, waddr, vd);
    @(negedge clk);
    check({tag, ":wr_en"}, wr_en, 1);
    check({tag, ":waddr"}, waddr, vd);
    check({tag, ":lmul"}, lmul, lm);
    check_wide({tag, ":wdata"}, wdata, exp_w);
    last_w = wdata;
    @(negedge clk);
    check({tag, ":wr_once"}, wr_en, 0);
    if (kind == 3) begin
      n = 0;
      while (!wb_error && n < 40) begin
        @(negedge clk);
        n++;
      end
      check({tag, ":timeout_cyc"}, n, TO);
      check({tag, ":timeout_done"}, wb_done, 0);
      check({tag, ":timeout_addr"}, waddr, vd);
      @(negedge clk);
    end else begin
      repeat (dly) @(negedge clk);
      data_written = (kind == 0) || (kind == 2);
      wrong_addr   = (kind == 1) || (kind == 2);
      #1;
      check({tag, ":done"}, wb_done, (kind != 1));
      check({tag, ":err"}, wb_error, (kind == 1));
      check_wide({tag, ":wdata_hold"}, wdata, exp_w);
      @(negedge clk);
      data_written = 1'b0;
      wrong_addr   = 1'b0;
    end
    check({tag, ":done_once"}, wb_done, 0);
    check({tag, ":ready_back"}, res_ready, 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    res_vd = '0;
    res_lmul = 4'd1;
    res_sew = 2'd0;
    res_vl = '0;
    res_vm = 1'b1;
    v0_mask_data = '0;
    dst_data = '0;
    data_written = 1'b0;
    wrong_addr = 1'b0;
    exp_w = '0;
    last_w = '0;

    tbl[0] = '{4'b0001, 2'b10, 16,   1'b1, 5'd4,  0, 0, 0};
    tbl[1] = '{4'b0001, 2'b00, 8,    1'b0, 5'd2,  0, 1, 1};
    tbl[2] = '{4'b0010, 2'b01, 20,   1'b1, 5'd3,  1, 2, 0};
    tbl[3] = '{4'b0100, 2'b00, 100,  1'b0, 5'd8,  2, 0, 0};
    tbl[4] = '{4'b1000, 2'b10, 0,    1'b1, 5'd16, 0, 3, 0};
    tbl[5] = '{4'b0001, 2'b00, 4000, 1'b1, 5'd5,  0, 0, 0};
    tbl[6] = '{4'b0001, 2'b11, 5,    1'b1, 5'd6,  0, 0, 0};
    tbl[7] = '{4'b0011, 2'b00, 5,    1'b1, 5'd7,  0, 0, 0};
    tbl[8] = '{4'b0010, 2'b10, 10,   1'b0, 5'd9,  3, 0, 0};
    tbl[9] = '{4'b0001, 2'b01, 30,   1'b0, 5'd0,  0, 4, 0};

    repeat (3) @(negedge clk);
    check("rst_ready", res_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_waddr", waddr, 0);
    check_wide("rst_wdata", wdata, '0);
    check("rst_lmul", lmul, 4'b0001);
    check("rst_done", wb_done, 0);
    check("rst_error", wb_error, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      set_pat(tbl[i].pat);
      txn(tbl[i].lm, tbl[i].sw, tbl[i].vl, tbl[i].vm, tbl[i].vd,
          tbl[i].kind, tbl[i].dly, $sformatf("tbl%0d", i));
      if (i == 1) begin
        check("mask_bytes0_7", last_w[63:0], 64'h11EE11EEEE11EE11);
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
        check("mask_byte8", last_w[71:64], 8'hFF);
`else
        check("mask_byte8", last_w[71:64], 8'hEE);
`endif
      end
    end

    // Reset during WAIT_ACK abandons the writeback.
    set_pat(0);
    res_valid = 1'b1;
    res_lmul  = 4'b0001;
    res_sew   = 2'b00;
    res_vl    = VLW'(40);
    res_vm    = 1'b1;
    res_vd    = 5'd12;
    @(negedge clk);
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", res_ready, 1);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_waddr", waddr, 0);
    check_wide("midrst_wdata", wdata, '0);
    check("midrst_lmul", lmul, 4'b0001);
    check("midrst_done", wb_done, 0);
    check("midrst_error", wb_error, 0);
    @(negedge clk);
    reset = 1'b1;
    data_written = 1'b1;
    #1;
    check("postrst_no_done", wb_done, 0);
    begin
      int wr_seen;
      wr_seen = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        data_written = 1'b0;
        wr_seen += int'(wr_en);
      end
      check("postrst_no_write", wr_seen, 0);
    end
    set_pat(0);
    txn(4'b0010, 2'b01, 50, 1'b0, 5'd14, 0, 1, "postrst");

    // Random transactions against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [3:0] lm;
      logic [1:0] sw;
      lm = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) lm = 4'b0110;
      sw = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 14) == 0) sw = 2'b11;
      set_pat(0);
      txn(lm, sw, $urandom_range(0, 600), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 31)), $urandom_range(0, 2),
          $urandom_range(0, 6), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
